// File: rtl/jt12_opsum_if.sv
// Operator-stream bundle between the FM operator pipeline and the channel/stereo summer.
interface jt12_opsum_if;
  logic               clk_en;
  logic signed [8:0]  op_result;
  logic [2:0]         alg;
  logic [1:0]         rl;
  logic               s1_enters;
  logic               s2_enters;
  logic               s3_enters;
  logic               s4_enters;
  logic               zero;
  logic signed [11:0] left;
  logic signed [11:0] right;
  logic               sample;

  modport master (
    output clk_en, op_result, alg, rl, s1_enters, s2_enters, s3_enters, s4_enters, zero,
    input  left, right, sample
  );

  modport slave (
    input  clk_en, op_result, alg, rl, s1_enters, s2_enters, s3_enters, s4_enters, zero,
    output left, right, sample
  );
endinterface

// File: rtl/jt12_opsum.sv
// Per-channel carrier summer: time-multiplexed channel accumulator, 9-bit clamp,
// stereo panning into frame accumulators, one left/right sample per frame.
module jt12_opsum #(
  parameter int num_ch = 6
) (
  input  logic        clk,
  input  logic        rst,
  jt12_opsum_if.slave bus
);

  logic signed [11:0] r_acc [num_ch];
  logic signed [11:0] r_lacc;
  logic signed [11:0] r_racc;
  logic               r_primed;
  logic signed [11:0] r_left;
  logic signed [11:0] r_right;
  logic               r_sample;

  logic               w_sum_en;
  logic signed [11:0] w_contrib;
  logic signed [11:0] w_new;
  logic signed [11:0] w_chsum;
  logic signed [11:0] w_lacc_nxt;
  logic signed [11:0] w_racc_nxt;

  function automatic logic signed [11:0] clamp9(input logic signed [11:0] x);
    if (x > 12'sd255)
      return 12'sd255;
    else if (x < -12'sd256)
      return -12'sd256;
    else
      return x;
  endfunction

  // Slot stage: carrier selection, channel accumulation and channel clamp
  always_comb begin
    w_sum_en = 1'b0;
    case (bus.alg)
      3'd0, 3'd1, 3'd2, 3'd3: w_sum_en = bus.s4_enters;
      3'd4:                   w_sum_en = bus.s2_enters | bus.s4_enters;
      3'd5, 3'd6:             w_sum_en = ~bus.s1_enters;
      default:                w_sum_en = 1'b1;
    endcase
    w_contrib  = w_sum_en ? {{3{bus.op_result[8]}}, bus.op_result} : 12'sd0;
    // S1 starts a fresh channel sum; otherwise continue from the value pushed num_ch slots ago
    w_new      = (bus.s1_enters ? 12'sd0 : r_acc[num_ch-1]) + w_contrib;
    w_chsum    = clamp9(w_new);
    w_lacc_nxt = (bus.zero ? 12'sd0 : r_lacc)
               + ((bus.s4_enters & bus.rl[1]) ? w_chsum : 12'sd0);
    w_racc_nxt = (bus.zero ? 12'sd0 : r_racc)
               + ((bus.s4_enters & bus.rl[0]) ? w_chsum : 12'sd0);
  end

  // Register stage: shift chain, frame accumulators, frame-boundary output latch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_ch; i++) r_acc[i] <= 12'sd0;
      r_lacc   <= 12'sd0;
      r_racc   <= 12'sd0;
      r_primed <= 1'b0;
      r_left   <= 12'sd0;
      r_right  <= 12'sd0;
      r_sample <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      if (bus.clk_en) begin
        r_acc[0] <= w_new;
        for (int i = 1; i < num_ch; i++) r_acc[i] <= r_acc[i-1];
        r_lacc <= w_lacc_nxt;
        r_racc <= w_racc_nxt;
        if (bus.zero) begin
          r_primed <= 1'b1;
          // Without a prior zero the accumulators hold a partial frame; drop it
          if (r_primed) begin
            r_left   <= r_lacc;
            r_right  <= r_racc;
            r_sample <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.left   = r_left;
  assign bus.right  = r_right;
  assign bus.sample = r_sample;

endmodule

// File: tb/tb_jt12_opsum.sv
// Directed bench for jt12_opsum: frame-level reference model feeding a scoreboard
// that is drained whenever the DUT pulses sample.
module tb_jt12_opsum;

  logic clk;
  logic rst;

  jt12_opsum_if bus ();

  jt12_opsum #(.num_ch(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_push = 0;
  int n_samp = 0;

  logic signed [11:0] q_l [$];
  logic signed [11:0] q_r [$];

  // frame data: op index 0..3 = S1, S2, S3, S4
  logic signed [8:0] f_op  [6][4];
  logic [2:0]        f_alg [6];
  logic [1:0]        f_rl  [6];

  logic prev_ez   = 1'b0;
  logic prev_samp = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic bit carrier(input logic [2:0] a, input int o);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return (o == 3);
      3'd4:                   return (o == 1 || o == 3);
      3'd5, 3'd6:             return (o != 0);
      default:                return 1'b1;
    endcase
  endfunction

  task automatic sb_push();
    int l = 0;
    int r = 0;
    for (int c = 0; c < 6; c++) begin
      int s = 0;
      for (int o = 0; o < 4; o++)
        if (carrier(f_alg[c], o)) s += int'(f_op[c][o]);
      if (s > 255)  s = 255;
      if (s < -256) s = -256;
      if (f_rl[c][1]) l += s;
      if (f_rl[c][0]) r += s;
    end
    q_l.push_back(12'(l));
    q_r.push_back(12'(r));
    n_push++;
  endtask

  task automatic fill(input int op, input logic [2:0] a, input logic [1:0] pan);
    for (int c = 0; c < 6; c++) begin
      for (int o = 0; o < 4; o++) f_op[c][o] = 9'(op);
      f_alg[c] = a;
      f_rl[c]  = pan;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slots in frame order S1, S3, S2, S4; gap = disabled cycles after each enabled one
  task automatic drive_slots(input int start, input int n, input int gap);
    for (int s = start; s < start + n; s++) begin
      int c = s % 6;
      int g = s / 6;
      int o = (g == 1) ? 2 : (g == 2) ? 1 : g;
      bus.zero      = (s == 0);
      bus.s1_enters = (o == 0);
      bus.s2_enters = (o == 1);
      bus.s3_enters = (o == 2);
      bus.s4_enters = (o == 3);
      bus.op_result = f_op[c][o];
      bus.alg       = f_alg[c];
      bus.rl        = f_rl[c];
      bus.clk_en    = 1'b1;
      tick();
      repeat (gap) begin
        bus.clk_en = 1'b0;
        tick();
      end
    end
  endtask

  task automatic frame(input int gap);
    sb_push();
    drive_slots(0, 24, gap);
  endtask

  task automatic flush();
    bus.zero      = 1'b1;
    bus.s1_enters = 1'b0;
    bus.s2_enters = 1'b0;
    bus.s3_enters = 1'b0;
    bus.s4_enters = 1'b0;
    bus.op_result = '0;
    bus.clk_en    = 1'b1;
    tick();
    bus.clk_en = 1'b0;
    bus.zero   = 1'b0;
    repeat (6) tick();
  endtask

  always @(negedge clk) begin
    if (bus.sample === 1'b1) begin
      n_samp++;
      chk("sample_after_enabled_zero", prev_ez, 1);
      chk("sample_single_pulse", prev_samp, 0);
      chk("scoreboard_nonempty", (q_l.size() != 0), 1);
      if (q_l.size() != 0) begin
        chk("left",  bus.left,  q_l.pop_front());
        chk("right", bus.right, q_r.pop_front());
      end
    end
    prev_samp = bus.sample;
    prev_ez   = bus.clk_en & bus.zero & ~rst;
  end

  initial begin
    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.op_result = '0;
    bus.alg       = '0;
    bus.rl        = '0;
    bus.s1_enters = 1'b0;
    bus.s2_enters = 1'b0;
    bus.s3_enters = 1'b0;
    bus.s4_enters = 1'b0;
    bus.zero      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_left",   bus.left,   0);
    chk("reset_right",  bus.right,  0);
    chk("reset_sample", bus.sample, 0);

    // alg7 single channel, four operators of +10
    fill(0, 3'd0, 2'b11);
    for (int o = 0; o < 4; o++) f_op[0][o] = 9'sd10;
    f_alg[0] = 3'd7;
    frame(0);

    // alg0 keeps only S4; alg4 keeps S2 and S4
    fill(0, 3'd0, 2'b11);
    for (int o = 0; o < 3; o++) f_op[0][o] = 9'sd100;
    f_op[0][3] = 9'sd50;
    frame(0);
    f_alg[0] = 3'd4;
    frame(0);

    // channel clamp at both ends
    fill(200, 3'd7, 2'b11);
    frame(0);
    fill(-256, 3'd7, 2'b11);
    frame(0);

    // mid-frame reset: partial frame discarded, first zero only primes
    fill(0, 3'd0, 2'b11);
    for (int o = 0; o < 4; o++) f_op[0][o] = 9'sd10;
    f_alg[0] = 3'd7;
    drive_slots(0, 12, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_left",   bus.left,   0);
    chk("midreset_right",  bus.right,  0);
    chk("midreset_sample", bus.sample, 0);
    drive_slots(12, 12, 0);
    frame(0);
    chk("primed_hold_left",  bus.left,  0);
    chk("primed_hold_right", bus.right, 0);

    // panning
    f_rl[0] = 2'b10;
    frame(0);
    f_rl[0] = 2'b00;
    frame(0);

    // mixed algorithms 5, 6, 4 with negative operators and one-sided pans
    fill(0, 3'd0, 2'b11);
    f_alg[0] = 3'd5;
    f_op[0][0] = 9'sd100; f_op[0][1] = 9'sd1;  f_op[0][2] = 9'sd2;  f_op[0][3] = 9'sd3;
    f_alg[1] = 3'd6; f_rl[1] = 2'b01;
    f_op[1][0] = 9'sd50;  f_op[1][1] = -9'sd5; f_op[1][2] = -9'sd6; f_op[1][3] = -9'sd7;
    f_alg[2] = 3'd4; f_rl[2] = 2'b10;
    f_op[2][0] = 9'sd9;   f_op[2][1] = 9'sd20; f_op[2][2] = 9'sd30; f_op[2][3] = -9'sd40;
    frame(0);

    // clk_en at 1/3 duty with the single-channel +10 stimulus
    fill(0, 3'd0, 2'b11);
    for (int o = 0; o < 4; o++) f_op[0][o] = 9'sd10;
    f_alg[0] = 3'd7;
    frame(2);
    f_op[1][3] = 9'sd77;
    frame(2);

    flush();
    chk("scoreboard_drained", q_l.size(), 0);
    chk("sample_count", n_samp, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
